// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encoding and counter sizing for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  // Shared timer width: enough bits to hold the largest bound minus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, qualifies lock, issues system reset request
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       pll_lock_i,
  input  logic       retry_i,
  output logic       pll_resetb_o,
  output logic       sys_rst_n_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int TW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  logic          lock_s;
  pll_state_e    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    retry_cnt, retry_nxt;
  logic [7:0]    loss_cnt, loss_nxt;
  logic          resetb_nxt, sys_nxt, locked_nxt, fail_nxt;

  sync_2ff u_lock_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_HOLD;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    case (state)
      ST_HOLD: begin
        if (timer == HOLD_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // The lock cycle seen here is the first of the stable run.
        if (lock_s) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
            retry_nxt = '0;
          end else begin
            state_nxt = ST_STABLE;
            timer_nxt = TW'(1);
          end
        end else if (timer == WAIT_LAST) begin
          retry_nxt = retry_cnt + 4'd1;
          timer_nxt = '0;
          state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
        timer_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_HOLD;
          if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
        end
      end
      ST_FAIL: begin
        timer_nxt = '0;
        if (retry_i) begin
          state_nxt = ST_HOLD;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs decode the next state so they register in step with the state.
  always_comb begin
    resetb_nxt = (state_nxt != ST_HOLD) && (state_nxt != ST_FAIL);
    sys_nxt    = (state_nxt == ST_RUN);
    locked_nxt = (state_nxt == ST_RUN);
    fail_nxt   = (state_nxt == ST_FAIL);
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      pll_resetb_o <= 1'b0;
      sys_rst_n_o  <= 1'b0;
      locked_o     <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      pll_resetb_o <= resetb_nxt;
      sys_rst_n_o  <= sys_nxt;
      locked_o     <= locked_nxt;
      fail_o       <= fail_nxt;
    end
  end

  assign state_o         = state;
  assign retry_cnt_o     = retry_cnt;
  assign lock_loss_cnt_o = loss_cnt;

endmodule
